// File: rtl/lbm_stream_scatter.sv
// D2Q9 LBM streaming stage: latches one post-collision cell and scatters its nine
// distributions to the neighbour cells of the next-timestep memory, one word per cycle.
//
//   state   | meaning
//   IDLE    | no cell held, ready for a handshake
//   SCATTER | writing direction dir_q of the latched cell; ready again at dir 8
module lbm_stream_scatter #(
  parameter int GRID_DIM      = 256,
  parameter int GRID_X        = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
  parameter int DATA_WIDTH_F  = 9 * DATA_WIDTH,
  parameter int BOUNCE_Y      = 0
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH_F-1:0]  in_f,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [3:0]               wr_dir,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [ADDRESS_WIDTH-1:0] cell_count,
  output logic                     frame_done
);

  localparam int XW     = $clog2(GRID_X);
  localparam int YW     = ADDRESS_WIDTH - XW;
  localparam int GRID_Y = GRID_DIM / GRID_X;

  typedef enum logic {IDLE, SCATTER} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               dir_q, dir_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH_F-1:0]  f_q, f_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

  logic last_dir, handshake;

  assign last_dir  = (state_q == SCATTER) && (dir_q == 4'd8);
  assign in_ready  = (state_q == IDLE) || last_dir;
  assign handshake = in_valid && in_ready;

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      dir_q   <= '0;
      addr_q  <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    if (state_q == SCATTER) begin
      if (dir_q == 4'd8) begin
        // GRID_DIM is a power of two, so the natural wrap ends the frame at 0
        cnt_d   = cnt_q + 1'b1;
        dir_d   = '0;
        state_d = IDLE;
      end else begin
        dir_d = dir_q + 1'b1;
      end
    end
    if (handshake) begin
      state_d = SCATTER;
      dir_d   = '0;
      addr_d  = in_addr;
      f_d     = in_f;
    end
  end

  logic       x_inc, x_dec, y_inc, y_dec;
  logic [3:0] opp_dir;

  always_comb begin
    x_inc   = 1'b0;
    x_dec   = 1'b0;
    y_inc   = 1'b0;
    y_dec   = 1'b0;
    opp_dir = 4'd0;
    case (dir_q)
      4'd1: begin x_inc = 1'b1;                 opp_dir = 4'd3; end
      4'd2: begin y_inc = 1'b1;                 opp_dir = 4'd4; end
      4'd3: begin x_dec = 1'b1;                 opp_dir = 4'd1; end
      4'd4: begin y_dec = 1'b1;                 opp_dir = 4'd2; end
      4'd5: begin x_inc = 1'b1; y_inc = 1'b1;   opp_dir = 4'd7; end
      4'd6: begin x_dec = 1'b1; y_inc = 1'b1;   opp_dir = 4'd8; end
      4'd7: begin x_dec = 1'b1; y_dec = 1'b1;   opp_dir = 4'd5; end
      4'd8: begin x_inc = 1'b1; y_dec = 1'b1;   opp_dir = 4'd6; end
      default: opp_dir = 4'd0;
    endcase
  end

  logic [XW-1:0] x_src, x_dst;
  logic [YW-1:0] y_src, y_dst;
  logic          hit_wall;

  assign x_src = addr_q[XW-1:0];
  assign y_src = addr_q[ADDRESS_WIDTH-1:XW];
  // Truncation to the field width gives the periodic wrap for free
  assign x_dst = x_inc ? x_src + XW'(1) : (x_dec ? x_src - XW'(1) : x_src);
  assign y_dst = y_inc ? y_src + YW'(1) : (y_dec ? y_src - YW'(1) : y_src);
  assign hit_wall = (BOUNCE_Y != 0) &&
                    ((y_dec && (y_src == '0)) || (y_inc && (y_src == YW'(GRID_Y - 1))));

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < 9; k++) begin
      if (dir_q == 4'(k)) wr_data = f_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign wr_en      = (state_q == SCATTER);
  assign wr_addr    = hit_wall ? addr_q : {y_dst, x_dst};
  assign wr_dir     = hit_wall ? opp_dir : dir_q;
  assign cell_count = cnt_q;
  assign frame_done = last_dir && (cnt_q == ADDRESS_WIDTH'(GRID_DIM - 1));

endmodule

// File: tb/tb_lbm_stream_scatter.sv
// Scoreboard bench for lbm_stream_scatter: a periodic and a bounce-back instance share
// the same stimulus, and each write is checked against a per-instance expected queue.
module tb_lbm_stream_scatter;

  localparam int GD = 256;
  localparam int GX = 16;
  localparam int GY = GD / GX;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CX[9]  = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int CY[9]  = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  localparam int OPP[9] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [9*DW-1:0] in_f = '0;

  logic          in_ready   [2];
  logic          wr_en      [2];
  logic [AW-1:0] wr_addr    [2];
  logic [3:0]    wr_dir     [2];
  logic [DW-1:0] wr_data    [2];
  logic [AW-1:0] cell_count [2];
  logic          frame_done [2];

  always #5 clk = ~clk;

  lbm_stream_scatter #(.GRID_DIM(GD), .GRID_X(GX), .DATA_WIDTH(DW), .BOUNCE_Y(0)) u_dut_p (
    .CLOCK_50(clk), .RESET(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_addr(in_addr), .in_f(in_f), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_dir(wr_dir[0]), .wr_data(wr_data[0]), .cell_count(cell_count[0]),
    .frame_done(frame_done[0]));

  lbm_stream_scatter #(.GRID_DIM(GD), .GRID_X(GX), .DATA_WIDTH(DW), .BOUNCE_Y(1)) u_dut_b (
    .CLOCK_50(clk), .RESET(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_addr(in_addr), .in_f(in_f), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_dir(wr_dir[1]), .wr_data(wr_data[1]), .cell_count(cell_count[1]),
    .frame_done(frame_done[1]));

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    dir;
    logic [DW-1:0] data;
    logic          fd;
    logic [AW-1:0] cnt;
  } wr_t;

  wr_t q_p[$];
  wr_t q_b[$];
  int  cnt_m = 0;
  int  cyc = 0;
  int  n_wr [2] = '{0, 0};
  int  n_fd [2] = '{0, 0};

  always @(posedge clk) cyc++;

  function automatic wr_t model(int a, int k, bit bounce, logic [DW-1:0] d, logic fd, int cnt);
    wr_t r;
    int x, y, nx, ny;
    x  = a % GX;
    y  = a / GX;
    nx = (x + CX[k] + GX) % GX;
    ny = y + CY[k];
    if (bounce && (ny < 0 || ny > GY - 1)) begin
      r.addr = AW'(a);
      r.dir  = 4'(OPP[k]);
    end else begin
      r.addr = AW'(((ny + GY) % GY) * GX + nx);
      r.dir  = 4'(k);
    end
    r.data = d;
    r.fd   = fd;
    r.cnt  = AW'(cnt);
    return r;
  endfunction

  task automatic push_cell(input int a, input logic [9*DW-1:0] f);
    logic fd;
    for (int k = 0; k < 9; k++) begin
      fd = (k == 8) && (cnt_m == GD - 1);
      q_p.push_back(model(a, k, 1'b0, f[k*DW +: DW], fd, cnt_m));
      q_b.push_back(model(a, k, 1'b1, f[k*DW +: DW], fd, cnt_m));
    end
    cnt_m = (cnt_m + 1) % GD;
  endtask

  task automatic send(input int a, input logic [9*DW-1:0] f, input bit hold, output int hs_cyc);
    hs_cyc = -1;
    @(negedge clk);
    in_valid = 1'b1;
    in_addr  = AW'(a);
    in_f     = f;
    for (int t = 0; !(in_ready[0] && in_ready[1]); t++) begin
      if (t >= 40) begin
        chk("handshake_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    push_cell(a, f);
    hs_cyc = cyc;
    @(posedge clk);
    if (!hold) begin
      #1 in_valid = 1'b0;
    end
  endtask

  function automatic logic [9*DW-1:0] rand_f();
    logic [9*DW-1:0] f;
    for (int k = 0; k < 9; k++) f[k*DW +: DW] = $urandom();
    return f;
  endfunction

  task automatic drain();
    for (int t = 0; t < 200 && (q_p.size() != 0 || q_b.size() != 0); t++) @(negedge clk);
    chk("drain_p", q_p.size(), 0);
    chk("drain_b", q_b.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  wr_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) begin
          n_wr[i]++;
          if ((i == 0 ? q_p.size() : q_b.size()) == 0) begin
            chk($sformatf("d%0d_unexpected_write", i), 1, 0);
          end else begin
            e = (i == 0) ? q_p.pop_front() : q_b.pop_front();
            chk($sformatf("d%0d_wr_addr", i), wr_addr[i], e.addr);
            chk($sformatf("d%0d_wr_dir", i), wr_dir[i], e.dir);
            chk($sformatf("d%0d_wr_data", i), wr_data[i], e.data);
            chk($sformatf("d%0d_frame_done", i), frame_done[i], e.fd);
            chk($sformatf("d%0d_cell_count", i), cell_count[i], e.cnt);
          end
        end else if (frame_done[i]) begin
          chk($sformatf("d%0d_frame_done_idle", i), 1, 0);
        end
        if (frame_done[i]) n_fd[i]++;
      end
    end
  end

  initial begin
    logic [9*DW-1:0] f;
    int h, prev, wr0[2], fd0[2];

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_rst_in_ready", i), in_ready[i], 1);
      chk($sformatf("d%0d_rst_wr_en", i), wr_en[i], 0);
      chk($sformatf("d%0d_rst_frame_done", i), frame_done[i], 0);
      chk($sformatf("d%0d_rst_cell_count", i), cell_count[i], 0);
      chk($sformatf("d%0d_rst_wr_addr", i), wr_addr[i], 0);
      chk($sformatf("d%0d_rst_wr_dir", i), wr_dir[i], 0);
      chk($sformatf("d%0d_rst_wr_data", i), wr_data[i], 0);
    end
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < 9; k++) f[k*DW +: DW] = 32'h0100_0000 * (k + 1);
    send(17, f, 1'b0, h);
    send(255, rand_f(), 1'b0, h);
    send(250, rand_f(), 1'b0, h);
    send(0, rand_f(), 1'b0, h);
    send(5, rand_f(), 1'b0, h);
    send(240, rand_f(), 1'b0, h);
    send(15, rand_f(), 1'b0, h);
    send(100, rand_f(), 1'b1, prev);
    send(101, rand_f(), 1'b0, h);
    chk("pair_gap", h - prev, 9);
    drain();

    repeat (6) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d_idle_wr_en", i), wr_en[i], 0);
        chk($sformatf("d%0d_idle_in_ready", i), in_ready[i], 1);
        chk($sformatf("d%0d_idle_cell_count", i), cell_count[i], cnt_m);
      end
    end

    wr0[0] = n_wr[0];
    send(77, rand_f(), 1'b0, h);
    for (int t = 0; n_wr[0] < wr0[0] + 4; t++) begin
      if (t >= 30) begin
        chk("reset_wait_timeout", 1, 0);
        break;
      end
      @(posedge clk);
    end
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("d%0d_midreset_wr_en", i), wr_en[i], 0);
    q_p.delete();
    q_b.delete();
    cnt_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_post_rst_in_ready", i), in_ready[i], 1);
      chk($sformatf("d%0d_post_rst_cell_count", i), cell_count[i], 0);
    end
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk($sformatf("d%0d_post_rst_wr_en", i), wr_en[i], 0);
    end

    for (int i = 0; i < 2; i++) begin
      wr0[i] = n_wr[i];
      fd0[i] = n_fd[i];
    end
    prev = -1;
    for (int a = 0; a < GD; a++) begin
      send(a, rand_f(), a != GD - 1, h);
      if (a > 0) chk("frame_gap", h - prev, 9);
      prev = h;
    end
    drain();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_frame_writes", i), n_wr[i] - wr0[i], 9 * GD);
      chk($sformatf("d%0d_frame_done_pulses", i), n_fd[i] - fd0[i], 1);
      chk($sformatf("d%0d_frame_end_count", i), cell_count[i], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
